// File: rtl/instr_stream_encoder_if.sv
// Instruction stream encoder bus.
// Carries the load-source handshake, control strobes, the instruction-memory
// write port and the status outputs. Clock and reset stay outside the bundle.
interface instr_stream_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_opcode;
  logic [2:0]  in_rd;
  logic [2:0]  in_rs;
  logic [4:0]  in_flags;
  logic [15:0] in_imm;
  logic        load;
  logic [15:0] start_addr;
  logic        finish;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_wen;
  logic [15:0] wr_ptr;
  logic        full;
  logic        done;

  // Encoder side: consumes fields and control, drives memory port and status
  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs, in_flags, in_imm,
           load, start_addr, finish,
    output in_ready, mem_addr, mem_wdata, mem_wen, wr_ptr, full, done
  );

  // Loader side: produces fields and control, observes memory port and status
  modport master (
    output in_valid, in_opcode, in_rd, in_rs, in_flags, in_imm,
           load, start_addr, finish,
    input  in_ready, mem_addr, mem_wdata, mem_wen, wr_ptr, full, done
  );
endinterface

// File: rtl/instr_stream_encoder.sv
// Instruction stream encoder.
// Packs opcode/rd/rs/flags into 16-bit instruction words, appends the
// immediate for two-word opcodes, writes them sequentially into instruction
// memory and terminates the image with an STP word. All memory outputs are
// registered: a word accepted on an edge is visible on the write port during
// the following cycle, and the FSM state names what is being written then.
module instr_stream_encoder #(
  parameter logic [15:0] LAST_ADDR = 16'hFFFF
) (
  input  logic clk,
  input  logic reset,
  instr_stream_encoder_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EMIT1 = 2'd1;
  localparam logic [1:0] S_EMIT2 = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [15:0] STP_WORD = 16'hF800;

  // Two-word opcodes carry an immediate N in the following word
  function automatic logic isTwoWord(input logic [4:0] op);
    logic result;
    case (op)
      5'b00001, 5'b00011, 5'b00101, 5'b01001,
      5'b01011, 5'b01101, 5'b01111, 5'b10111: result = 1'b1;
      default:                                result = 1'b0;
    endcase
    return result;
  endfunction

  logic [1:0]  r_state;
  logic [16:0] r_wrPtr;
  logic        r_done;
  logic        r_finishPending;
  logic        r_twoWord;
  logic [15:0] r_imm;
  logic        r_memWen;
  logic [15:0] r_memAddr;
  logic [15:0] r_memWdata;

  logic [16:0] w_limit;
  logic [16:0] w_free;
  logic        w_full;
  logic        w_readyBase;
  logic        w_inReady;
  logic        w_accept;
  logic        w_finishReq;
  logic        w_stopNext;
  logic [15:0] w_word1;
  logic        w_isTwoWord;
  logic [16:0] w_ptrInc;

  // The pointer is kept one bit wider so that running past LAST_ADDR is
  // visible as "no free space" instead of silently wrapping to address 0.
  assign w_limit     = {1'b0, LAST_ADDR} + 17'd1;
  assign w_free      = (r_wrPtr > {1'b0, LAST_ADDR}) ? 17'd0 : (w_limit - r_wrPtr);
  assign w_full      = (w_free < 17'd3);
  assign w_readyBase = !w_full && !r_done && !r_finishPending && !reset;
  assign w_inReady   = ((r_state == S_IDLE) || ((r_state == S_EMIT1) && !r_twoWord))
                       && w_readyBase;
  assign w_accept    = bus.in_valid && w_inReady;
  assign w_finishReq = bus.finish && !r_done;
  assign w_stopNext  = r_finishPending || w_finishReq;
  assign w_word1     = {bus.in_opcode, bus.in_rd, bus.in_rs, bus.in_flags};
  assign w_isTwoWord = isTwoWord(bus.in_opcode);
  assign w_ptrInc    = r_wrPtr + 17'd1;

  assign bus.in_ready  = w_inReady;
  assign bus.mem_addr  = r_memAddr;
  assign bus.mem_wdata = r_memWdata;
  assign bus.mem_wen   = r_memWen;
  assign bus.wr_ptr    = r_wrPtr[15:0];
  assign bus.full      = w_full;
  assign bus.done      = r_done;

  // Sequencer: registers each memory write together with the state that
  // shows it, advances the pointer, and tracks the pending/sticky STP status.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_wrPtr         <= 17'd0;
      r_done          <= 1'b0;
      r_finishPending <= 1'b0;
      r_twoWord       <= 1'b0;
      r_imm           <= 16'd0;
      r_memWen        <= 1'b0;
      r_memAddr       <= 16'd0;
      r_memWdata      <= 16'd0;
    end else begin
      r_memWen <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_memWen   <= 1'b1;
            r_memAddr  <= r_wrPtr[15:0];
            r_memWdata <= w_word1;
            r_wrPtr    <= w_ptrInc;
            r_twoWord  <= w_isTwoWord;
            r_imm      <= bus.in_imm;
            r_state    <= S_EMIT1;
            if (w_finishReq) r_finishPending <= 1'b1;
          end else if (w_finishReq) begin
            r_memWen        <= 1'b1;
            r_memAddr       <= r_wrPtr[15:0];
            r_memWdata      <= STP_WORD;
            r_wrPtr         <= w_ptrInc;
            r_done          <= 1'b1;
            r_finishPending <= 1'b0;
            r_state         <= S_STOP;
          end else if (bus.load) begin
            r_wrPtr <= {1'b0, bus.start_addr};
            r_done  <= 1'b0;
          end
        end
        S_EMIT1: begin
          if (r_twoWord) begin
            r_memWen   <= 1'b1;
            r_memAddr  <= r_wrPtr[15:0];
            r_memWdata <= r_imm;
            r_wrPtr    <= w_ptrInc;
            r_state    <= S_EMIT2;
            if (w_finishReq) r_finishPending <= 1'b1;
          end else if (w_accept) begin
            r_memWen   <= 1'b1;
            r_memAddr  <= r_wrPtr[15:0];
            r_memWdata <= w_word1;
            r_wrPtr    <= w_ptrInc;
            r_twoWord  <= w_isTwoWord;
            r_imm      <= bus.in_imm;
            r_state    <= S_EMIT1;
            if (w_finishReq) r_finishPending <= 1'b1;
          end else if (w_stopNext) begin
            r_memWen        <= 1'b1;
            r_memAddr       <= r_wrPtr[15:0];
            r_memWdata      <= STP_WORD;
            r_wrPtr         <= w_ptrInc;
            r_done          <= 1'b1;
            r_finishPending <= 1'b0;
            r_state         <= S_STOP;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_EMIT2: begin
          if (w_stopNext) begin
            r_memWen        <= 1'b1;
            r_memAddr       <= r_wrPtr[15:0];
            r_memWdata      <= STP_WORD;
            r_wrPtr         <= w_ptrInc;
            r_done          <= 1'b1;
            r_finishPending <= 1'b0;
            r_state         <= S_STOP;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_STOP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Testbench for instr_stream_encoder.
// Two instances: dutA with the full address space, dutB with LAST_ADDR=4 for
// the space-exhaustion case. Expected memory writes are queued as stimulus is
// driven and popped by per-instance write monitors.
module tb_instr_stream_encoder;

  logic clk;
  logic reset;

  int checks = 0;
  int errors = 0;

  logic [31:0] expA[$];
  logic [31:0] expB[$];
  logic [31:0] expWordA;
  logic [31:0] expWordB;

  instr_stream_encoder_if ifA ();
  instr_stream_encoder_if ifB ();

  instr_stream_encoder dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (ifA)
  );

  instr_stream_encoder #(.LAST_ADDR(16'h0004)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (ifB)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic valid, input logic [4:0] op,
                               input logic [2:0] rd, input logic [2:0] rs,
                               input logic [4:0] fl, input logic [15:0] imm);
    ifA.in_valid  = valid;
    ifA.in_opcode = op;
    ifA.in_rd     = rd;
    ifA.in_rs     = rs;
    ifA.in_flags  = fl;
    ifA.in_imm    = imm;
  endtask

  // Write monitor for dutA: every write must match the next queued word
  always @(negedge clk) begin
    if (ifA.mem_wen === 1'b1) begin
      if (expA.size() == 0) begin
        checks++;
        errors++;
        $error("[TB] FAIL A spurious write observed addr=%h data=%h expected none",
               ifA.mem_addr, ifA.mem_wdata);
      end else begin
        expWordA = expA.pop_front();
        checkOutput("A write addr/data", {ifA.mem_addr, ifA.mem_wdata}, expWordA);
      end
    end
  end

  // Write monitor for dutB: every write must match the next queued word
  always @(negedge clk) begin
    if (ifB.mem_wen === 1'b1) begin
      if (expB.size() == 0) begin
        checks++;
        errors++;
        $error("[TB] FAIL B spurious write observed addr=%h data=%h expected none",
               ifB.mem_addr, ifB.mem_wdata);
      end else begin
        expWordB = expB.pop_front();
        checkOutput("B write addr/data", {ifB.mem_addr, ifB.mem_wdata}, expWordB);
      end
    end
  end

  // Directed sequence
  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 5'd0, 3'd0, 3'd0, 5'd0, 16'd0);
    ifA.load = 1'b0; ifA.start_addr = 16'd0; ifA.finish = 1'b0;
    ifB.in_valid = 1'b0; ifB.in_opcode = 5'd0; ifB.in_rd = 3'd0; ifB.in_rs = 3'd0;
    ifB.in_flags = 5'd0; ifB.in_imm = 16'd0;
    ifB.load = 1'b0; ifB.start_addr = 16'd0; ifB.finish = 1'b0;

    // Reset cycle and reset values
    sample();
    checkOutput("in_ready during reset", 32'(ifA.in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    sample();
    checkOutput("reset in_ready", 32'(ifA.in_ready), 32'd1);
    checkOutput("reset mem_wen", 32'(ifA.mem_wen), 32'd0);
    checkOutput("reset mem_addr", 32'(ifA.mem_addr), 32'd0);
    checkOutput("reset mem_wdata", 32'(ifA.mem_wdata), 32'd0);
    checkOutput("reset wr_ptr", 32'(ifA.wr_ptr), 32'd0);
    checkOutput("reset done", 32'(ifA.done), 32'd0);
    checkOutput("reset full", 32'(ifA.full), 32'd0);

    // ADD R rd=1 rs=2 -> 16'h4140 at 0
    expA.push_back({16'h0000, 16'h4140});
    applyStimulus(1'b1, 5'b01000, 3'd1, 3'd2, 5'd0, 16'hFFFF);
    tick();
    applyStimulus(1'b0, 5'd0, 3'd0, 3'd0, 5'd0, 16'd0);
    sample();
    checkOutput("ADD mem_wen", 32'(ifA.mem_wen), 32'd1);
    checkOutput("ADD wr_ptr", 32'(ifA.wr_ptr), 32'd1);
    tick(); tick();

    // load 0x0010 then JMP I N=0x0123
    ifA.load = 1'b1; ifA.start_addr = 16'h0010;
    tick();
    ifA.load = 1'b0;
    sample();
    checkOutput("load wr_ptr", 32'(ifA.wr_ptr), 32'h0010);
    expA.push_back({16'h0010, 16'h2800});
    expA.push_back({16'h0011, 16'h0123});
    applyStimulus(1'b1, 5'b00101, 3'd0, 3'd0, 5'd0, 16'h0123);
    tick();
    applyStimulus(1'b0, 5'd0, 3'd0, 3'd0, 5'd0, 16'd0);
    sample();
    checkOutput("JMP EMIT1 in_ready", 32'(ifA.in_ready), 32'd0);
    checkOutput("JMP EMIT1 mem_wen", 32'(ifA.mem_wen), 32'd1);
    checkOutput("JMP EMIT1 wr_ptr", 32'(ifA.wr_ptr), 32'h0011);
    tick();
    sample();
    checkOutput("JMP EMIT2 mem_wen", 32'(ifA.mem_wen), 32'd1);
    checkOutput("JMP EMIT2 wr_ptr", 32'(ifA.wr_ptr), 32'h0012);
    tick(); tick();

    // Three back-to-back NOPs from address 0
    ifA.load = 1'b1; ifA.start_addr = 16'h0000;
    tick();
    ifA.load = 1'b0;
    for (int i = 0; i < 3; i++) expA.push_back({16'(i), 16'h0000});
    applyStimulus(1'b1, 5'd0, 3'd0, 3'd0, 5'd0, 16'hAAAA);
    for (int i = 0; i < 3; i++) begin
      sample();
      checkOutput("NOP burst in_ready", 32'(ifA.in_ready), 32'd1);
      if (i > 0) checkOutput("NOP burst mem_wen", 32'(ifA.mem_wen), 32'd1);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 3'd0, 3'd0, 5'd0, 16'd0);
    sample();
    checkOutput("NOP burst last mem_wen", 32'(ifA.mem_wen), 32'd1);
    checkOutput("NOP burst wr_ptr", 32'(ifA.wr_ptr), 32'd3);
    tick(); tick();

    // finish together with CALL N=0x0040
    ifA.load = 1'b1; ifA.start_addr = 16'h0000;
    tick();
    ifA.load = 1'b0;
    expA.push_back({16'h0000, 16'h0800});
    expA.push_back({16'h0001, 16'h0040});
    expA.push_back({16'h0002, 16'hF800});
    applyStimulus(1'b1, 5'b00001, 3'd0, 3'd0, 5'd0, 16'h0040);
    ifA.finish = 1'b1;
    tick();
    applyStimulus(1'b0, 5'd0, 3'd0, 3'd0, 5'd0, 16'd0);
    ifA.finish = 1'b0;
    tick(); tick(); tick();
    sample();
    checkOutput("CALL+finish done", 32'(ifA.done), 32'd1);
    checkOutput("CALL+finish wr_ptr", 32'(ifA.wr_ptr), 32'd3);
    applyStimulus(1'b1, 5'd0, 3'd0, 3'd0, 5'd0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      sample();
      checkOutput("after done in_ready", 32'(ifA.in_ready), 32'd0);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 3'd0, 3'd0, 5'd0, 16'd0);
    tick();

    // Reset during EMIT2 of MOV I
    ifA.load = 1'b1; ifA.start_addr = 16'h0000;
    tick();
    ifA.load = 1'b0;
    expA.push_back({16'h0000, 16'h7B00});
    expA.push_back({16'h0001, 16'hBEEF});
    applyStimulus(1'b1, 5'b01111, 3'd3, 3'd0, 5'd0, 16'hBEEF);
    tick();
    applyStimulus(1'b0, 5'd0, 3'd0, 3'd0, 5'd0, 16'd0);
    tick();
    reset = 1'b1;
    sample();
    checkOutput("MOV EMIT2 mem_wen", 32'(ifA.mem_wen), 32'd1);
    checkOutput("reset mid-op in_ready", 32'(ifA.in_ready), 32'd0);
    tick();
    reset = 1'b0;
    sample();
    checkOutput("post-reset mem_wen", 32'(ifA.mem_wen), 32'd0);
    checkOutput("post-reset mem_addr", 32'(ifA.mem_addr), 32'd0);
    checkOutput("post-reset mem_wdata", 32'(ifA.mem_wdata), 32'd0);
    checkOutput("post-reset wr_ptr", 32'(ifA.wr_ptr), 32'd0);
    checkOutput("post-reset done", 32'(ifA.done), 32'd0);
    checkOutput("post-reset in_ready", 32'(ifA.in_ready), 32'd1);
    expA.push_back({16'h0000, 16'h0215});
    applyStimulus(1'b1, 5'd0, 3'd2, 3'd0, 5'h15, 16'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 3'd0, 3'd0, 5'd0, 16'd0);
    sample();
    checkOutput("post-reset NOP wr_ptr", 32'(ifA.wr_ptr), 32'd1);
    tick(); tick();

    // dutB: exhaust space with LAST_ADDR=4, then STP still fits
    for (int i = 0; i < 3; i++) expB.push_back({16'(i), 16'h0000});
    ifB.in_valid = 1'b1;
    repeat (4) tick();
    ifB.in_valid = 1'b0;
    sample();
    checkOutput("B wr_ptr at full", 32'(ifB.wr_ptr), 32'd3);
    checkOutput("B full", 32'(ifB.full), 32'd1);
    checkOutput("B in_ready at full", 32'(ifB.in_ready), 32'd0);
    expB.push_back({16'h0003, 16'hF800});
    ifB.finish = 1'b1;
    tick();
    ifB.finish = 1'b0;
    tick();
    sample();
    checkOutput("B done", 32'(ifB.done), 32'd1);
    checkOutput("B final wr_ptr", 32'(ifB.wr_ptr), 32'd4);
    checkOutput("B idle mem_wen", 32'(ifB.mem_wen), 32'd0);
    ifB.in_valid = 1'b1;
    ifB.finish   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      checkOutput("B after done in_ready", 32'(ifB.in_ready), 32'd0);
      tick();
    end
    ifB.in_valid = 1'b0;
    ifB.finish   = 1'b0;
    tick(); tick();

    sample();
    checkOutput("A expected writes drained", 32'(expA.size()), 32'd0);
    checkOutput("B expected writes drained", 32'(expB.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
